// File: rtl/hex_entry_display_ctrl.sv
// hex_entry_display_ctrl
//   Hex digit entry controller for a bank of seven-segment displays. Four
//   slide switches supply a hex value; active-low push buttons write it into
//   digit registers either directly (one key per digit) or sequentially
//   (KEY[0] writes at a cursor and advances, KEY[1] clears everything).
//
//   Ports
//     CLOCK_125_p  in   sole clock, all state on rising edge
//     RESET_N      in   asynchronous active-low reset
//     SW[3:0]      in   hex value to load (asynchronous)
//     KEY[N-1:0]   in   active-low push buttons (asynchronous, bouncing)
//     MODE         in   0 = direct, 1 = sequential (asynchronous)
//     HEX[7N-1:0]  out  segment bus, digit i on [7i+6:7i], bit 0 = seg a
//     LOADED[N-1:0] out digit i written since reset/clear
//     CURSOR[2:0]  out  sequential-mode write position
//
//   Optional feature macro: HEX_DISP_BLINK_EN
//     When defined, the cursor digit blinks in sequential mode with a
//     half-period of BLINK_CYCLES. When undefined there is no blink logic.

module hex_entry_display_ctrl #(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter bit SEG_ACTIVE_LOW  = 1'b1,
   parameter int BLINK_CYCLES    = 31250000
) (
   input  logic                    CLOCK_125_p,
   input  logic                    RESET_N,
   input  logic [3:0]              SW,
   input  logic [NUM_DIGITS-1:0]   KEY,
   input  logic                    MODE,
   output logic [7*NUM_DIGITS-1:0] HEX,
   output logic [NUM_DIGITS-1:0]   LOADED,
   output logic [2:0]              CURSOR
);

   // Active-low glyph table, bits g..a
   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // ---------------------------------------------------------------
   // Two-flop synchronizers, reset to the inactive input levels
   // ---------------------------------------------------------------
   logic [3:0]            sw_meta_reg, sw_sync_reg;
   logic [NUM_DIGITS-1:0] key_meta_reg, key_sync_reg;
   logic                  mode_meta_reg, mode_sync_reg, mode_prev_reg;

   always_ff @(posedge CLOCK_125_p or negedge RESET_N) begin
      if (!RESET_N) begin
         sw_meta_reg   <= '0;
         sw_sync_reg   <= '0;
         key_meta_reg  <= '1;
         key_sync_reg  <= '1;
         mode_meta_reg <= 1'b0;
         mode_sync_reg <= 1'b0;
         mode_prev_reg <= 1'b0;
      end else begin
         sw_meta_reg   <= SW;
         sw_sync_reg   <= sw_meta_reg;
         key_meta_reg  <= KEY;
         key_sync_reg  <= key_meta_reg;
         mode_meta_reg <= MODE;
         mode_sync_reg <= mode_meta_reg;
         mode_prev_reg <= mode_sync_reg;
      end
   end

   // ---------------------------------------------------------------
   // Per-key debouncers. The press pulse is raised on the same edge the
   // debounced level falls, so it is valid for exactly one cycle.
   // ---------------------------------------------------------------
   logic [NUM_DIGITS-1:0] press_evt;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_deb
      logic [20:0] cnt_reg;
      logic        deb_reg;
      logic        press_reg;

      always_ff @(posedge CLOCK_125_p or negedge RESET_N) begin
         if (!RESET_N) begin
            cnt_reg   <= '0;
            deb_reg   <= 1'b1;
            press_reg <= 1'b0;
         end else if (key_sync_reg[gi] == deb_reg) begin
            // any agreement restarts the stability count
            cnt_reg   <= '0;
            press_reg <= 1'b0;
         end else if (cnt_reg == 21'(DEBOUNCE_CYCLES - 1)) begin
            cnt_reg   <= '0;
            deb_reg   <= key_sync_reg[gi];
            press_reg <= ~key_sync_reg[gi];
         end else begin
            cnt_reg   <= cnt_reg + 21'd1;
            press_reg <= 1'b0;
         end
      end

      assign press_evt[gi] = press_reg;
   end

   // ---------------------------------------------------------------
   // Digit / LOADED / CURSOR state
   // ---------------------------------------------------------------
   logic [3:0]            digit_reg  [NUM_DIGITS];
   logic [3:0]            digit_next [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] loaded_reg, loaded_next;
   logic [2:0]            cursor_reg, cursor_next;
   logic                  mode_change;

   assign mode_change = mode_sync_reg ^ mode_prev_reg;

   always_comb begin
      digit_next  = digit_reg;
      loaded_next = loaded_reg;
      cursor_next = cursor_reg;
      if (mode_change) begin
         // mode switch only homes the cursor; same-cycle events are dropped
         cursor_next = 3'd0;
      end else if (!mode_sync_reg) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (press_evt[i]) begin
               digit_next[i]  = sw_sync_reg;
               loaded_next[i] = 1'b1;
            end
         end
      end else if (press_evt[1]) begin
         // clear takes priority over a simultaneous write
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_next[i] = 4'h0;
         end
         loaded_next = '0;
         cursor_next = 3'd0;
      end else if (press_evt[0]) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cursor_reg == 3'(i)) begin
               digit_next[i]  = sw_sync_reg;
               loaded_next[i] = 1'b1;
            end
         end
         cursor_next = (cursor_reg == 3'(NUM_DIGITS - 1)) ? 3'd0 : cursor_reg + 3'd1;
      end
   end

   always_ff @(posedge CLOCK_125_p or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_reg[i] <= 4'h0;
         end
         loaded_reg <= '0;
         cursor_reg <= 3'd0;
      end else begin
         digit_reg  <= digit_next;
         loaded_reg <= loaded_next;
         cursor_reg <= cursor_next;
      end
   end

   // ---------------------------------------------------------------
   // Cursor blink
   // ---------------------------------------------------------------
   logic blink_hide;

`ifdef HEX_DISP_BLINK_EN
   logic [31:0] blink_cnt_reg;
   logic        blink_off_reg;

   always_ff @(posedge CLOCK_125_p or negedge RESET_N) begin
      if (!RESET_N) begin
         blink_cnt_reg <= '0;
         blink_off_reg <= 1'b0;
      end else if (!mode_sync_reg || (cursor_next != cursor_reg)) begin
         // restart phase with the glyph visible
         blink_cnt_reg <= '0;
         blink_off_reg <= 1'b0;
      end else if (blink_cnt_reg == 32'(BLINK_CYCLES - 1)) begin
         blink_cnt_reg <= '0;
         blink_off_reg <= ~blink_off_reg;
      end else begin
         blink_cnt_reg <= blink_cnt_reg + 32'd1;
      end
   end

   assign blink_hide = mode_sync_reg & blink_off_reg;
`else
   logic unused_blink_cfg;
   assign unused_blink_cfg = (BLINK_CYCLES > 0);
   assign blink_hide       = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Registered segment output
   // ---------------------------------------------------------------
   logic [7*NUM_DIGITS-1:0] hex_reg, hex_next;

   always_comb begin
      logic [6:0] seg;
      hex_next = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (loaded_reg[i] && !(blink_hide && (cursor_reg == 3'(i))))
            seg = glyph(digit_reg[i]);
         else
            seg = 7'h7F;
         hex_next[7*i +: 7] = SEG_ACTIVE_LOW ? seg : ~seg;
      end
   end

   always_ff @(posedge CLOCK_125_p or negedge RESET_N) begin
      if (!RESET_N)
         hex_reg <= {(7*NUM_DIGITS){SEG_ACTIVE_LOW}};
      else
         hex_reg <= hex_next;
   end

   assign HEX    = hex_reg;
   assign LOADED = loaded_reg;
   assign CURSOR = cursor_reg;

endmodule

// File: tb/tb_hex_entry_display_ctrl.sv
// Testbench for hex_entry_display_ctrl with NUM_DIGITS=4,
// DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, active-low segments.
module tb_hex_entry_display_ctrl;

   localparam logic [6:0] BL = 7'h7F;
   localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
   localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
   localparam logic [6:0] G8 = 7'h00, G9 = 7'h10, GA = 7'h08, GB = 7'h03;
   localparam logic [6:0] GC = 7'h46, GD = 7'h21, GE = 7'h06, GF = 7'h0E;

   logic        clk;
   logic        rst_n;
   logic [3:0]  sw;
   logic [3:0]  key;
   logic        mode;
   logic [27:0] hex;
   logic [3:0]  loaded;
   logic [2:0]  cursor;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic        mode;
      logic [3:0]  sw;
      logic [3:0]  mask;
      logic [27:0] hex;
      logic [3:0]  loaded;
      logic [2:0]  cursor;
   } vec_t;

   vec_t vecs [18];

   hex_entry_display_ctrl #(
      .NUM_DIGITS      (4),
      .DEBOUNCE_CYCLES (4),
      .SEG_ACTIVE_LOW  (1'b1),
      .BLINK_CYCLES    (8)
   ) dut (
      .CLOCK_125_p (clk),
      .RESET_N     (rst_n),
      .SW          (sw),
      .KEY         (key),
      .MODE        (mode),
      .HEX         (hex),
      .LOADED      (loaded),
      .CURSOR      (cursor)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else begin
         pass_cnt++;
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic press(input logic [3:0] mask);
      key = ~mask;
      tick(12);
      key = 4'hF;
      tick(12);
   endtask

   initial begin
      // mode, sw, pressed keys, expected HEX {d3,d2,d1,d0}, LOADED, CURSOR
      vecs[0]  = '{1'b0, 4'h5, 4'b0001, {BL, GA, BL, G5}, 4'b0101, 3'd0};
      vecs[1]  = '{1'b0, 4'h7, 4'b1001, {G7, GA, BL, G7}, 4'b1101, 3'd0};
      vecs[2]  = '{1'b0, 4'hC, 4'b0010, {G7, GA, GC, G7}, 4'b1111, 3'd0};
      vecs[3]  = '{1'b1, 4'h1, 4'b0001, {G7, GA, GC, G1}, 4'b1111, 3'd1};
      vecs[4]  = '{1'b1, 4'h2, 4'b0001, {G7, GA, G2, G1}, 4'b1111, 3'd2};
      vecs[5]  = '{1'b1, 4'h3, 4'b0001, {G7, G3, G2, G1}, 4'b1111, 3'd3};
      vecs[6]  = '{1'b1, 4'h4, 4'b0001, {G4, G3, G2, G1}, 4'b1111, 3'd0};
      vecs[7]  = '{1'b1, 4'hF, 4'b0001, {G4, G3, G2, GF}, 4'b1111, 3'd1};
      vecs[8]  = '{1'b1, 4'h9, 4'b0100, {G4, G3, G2, GF}, 4'b1111, 3'd1};
      vecs[9]  = '{1'b1, 4'h9, 4'b1000, {G4, G3, G2, GF}, 4'b1111, 3'd1};
      vecs[10] = '{1'b1, 4'h9, 4'b0010, {BL, BL, BL, BL}, 4'b0000, 3'd0};
      vecs[11] = '{1'b1, 4'hE, 4'b0001, {BL, BL, BL, GE}, 4'b0001, 3'd1};
      vecs[12] = '{1'b0, 4'hB, 4'b0000, {BL, BL, BL, GE}, 4'b0001, 3'd0};
      vecs[13] = '{1'b1, 4'hD, 4'b0001, {BL, BL, BL, GD}, 4'b0001, 3'd1};
      vecs[14] = '{1'b1, 4'h8, 4'b0001, {BL, BL, G8, GD}, 4'b0011, 3'd2};
      vecs[15] = '{1'b1, 4'h6, 4'b0011, {BL, BL, BL, BL}, 4'b0000, 3'd0};
      vecs[16] = '{1'b0, 4'h0, 4'b0100, {BL, G0, BL, BL}, 4'b0100, 3'd0};
      vecs[17] = '{1'b0, 4'hB, 4'b0010, {BL, G0, GB, BL}, 4'b0110, 3'd0};

      rst_n = 1'b0;
      sw    = 4'h0;
      key   = 4'hF;
      mode  = 1'b0;
      tick(3);
      check("reset hex", 32'(hex), 32'h0FFFFFFF);
      check("reset loaded", 32'(loaded), 32'h0);
      check("reset cursor", 32'(cursor), 32'h0);
      rst_n = 1'b1;
      tick(10);
      check("idle hex", 32'(hex), 32'h0FFFFFFF);

      // direct load latency: SW=A on KEY[2], change exactly 7 edges after first sample
      sw = 4'hA;
      tick(3);
      key = 4'b1011;
      tick(7);
      check("lat hex before", 32'(hex), 32'h0FFFFFFF);
      tick(1);
      check("lat digit2", 32'(hex[20:14]), 32'(GA));
      check("lat hex", 32'(hex), 32'({BL, GA, BL, BL}));
      check("lat loaded", 32'(loaded), 32'b0100);
      key = 4'hF;
      tick(12);

      // bouncing KEY[0]: low 2, high 1, low held
      sw = 4'h3;
      tick(3);
      key = 4'b1110;
      tick(2);
      key = 4'b1111;
      tick(1);
      key = 4'b1110;
      tick(7);
      check("bounce before", 32'(hex), 32'({BL, GA, BL, BL}));
      tick(1);
      check("bounce hex", 32'(hex), 32'({BL, GA, BL, G3}));
      check("bounce loaded", 32'(loaded), 32'b0101);
      key = 4'hF;
      tick(12);

      for (int i = 0; i < 18; i++) begin
         mode = vecs[i].mode;
         sw   = vecs[i].sw;
         tick(6);
         if (vecs[i].mask != 4'b0000)
            press(vecs[i].mask);
         else
            tick(6);
         check($sformatf("v%0d hex", i), 32'(hex), 32'(vecs[i].hex));
         check($sformatf("v%0d loaded", i), 32'(loaded), 32'(vecs[i].loaded));
         check($sformatf("v%0d cursor", i), 32'(cursor), 32'(vecs[i].cursor));
      end

      // reset during a held debounce at count 3
      mode = 1'b1;
      sw   = 4'h6;
      tick(6);
      press(4'b0001);
      check("pre-rst hex", 32'(hex), 32'({BL, G0, GB, G6}));
      check("pre-rst cursor", 32'(cursor), 32'd1);
      sw = 4'h9;
      tick(3);
      key = 4'b1110;
      tick(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst hex", 32'(hex), 32'h0FFFFFFF);
      check("async rst loaded", 32'(loaded), 32'h0);
      check("async rst cursor", 32'(cursor), 32'h0);
      key = 4'hF;
      tick(2);
      rst_n = 1'b1;
      tick(15);
      check("no load hex", 32'(hex), 32'h0FFFFFFF);
      check("no load loaded", 32'(loaded), 32'h0);

      // key held through reset release: event only after D+3 edges
      key = 4'b1110;
      tick(2);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(7);
      check("held before", 32'(hex), 32'h0FFFFFFF);
      tick(1);
      check("held hex", 32'(hex), 32'({BL, BL, BL, G9}));
      check("held cursor", 32'(cursor), 32'd1);
      key = 4'hF;
      tick(12);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/hex_entry_display_ctrl.md
HEX_ENTRY_DISPLAY_CTRL -- requirements
Module: hex_entry_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of seven-segment digits driven; legal range 2..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1250000: consecutive stable cycles required to accept a key level change (10 ms at 125 MHz); legal range 1..2^21-1.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit when bit is 0; 0 = inverted polarity.
REQ-004 Parameter BLINK_CYCLES, default 31250000: cursor blink half-period in cycles; used only with HEX_DISP_BLINK_EN.
REQ-005 CLOCK_125_p  input  1  sole clock; all state on rising edge.
REQ-006 RESET_N  input  1  asynchronous, active-low reset.
REQ-007 SW  input  4  hex value to load; asynchronous to clock.
REQ-008 KEY  input  NUM_DIGITS  active-low push buttons; asynchronous, bouncing.
REQ-009 MODE  input  1  0 = direct, 1 = sequential; asynchronous.
REQ-010 HEX  output  7*NUM_DIGITS  segment bus; digit i on bits [7i+6:7i], bit 0 = segment a, bit 6 = segment g.
REQ-011 LOADED  output  NUM_DIGITS  bit i set once digit i has been written since reset/clear.
REQ-012 CURSOR  output  3  sequential-mode write position, binary.

Function
REQ-013 SW, KEY and MODE SHALL each pass through a 2-flop synchronizer before use.
REQ-014 Each KEY bit SHALL have an independent debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-015 A press event for key i SHALL be a one-cycle pulse on the debounced not-pressed-to-pressed transition; releases generate no event.
REQ-016 Digit registers SHALL update on the clock edge after the press event; total latency from first edge sampling a stable low KEY to HEX change = DEBOUNCE_CYCLES + 3 cycles.
REQ-017 Direct mode: press event on KEY[i] SHALL load synchronized SW into digit i and set LOADED[i]; simultaneous events load the same value into all pressed digits.
REQ-018 Sequential mode: KEY[0] event SHALL load SW into digit CURSOR, set LOADED[CURSOR], then advance CURSOR; CURSOR = NUM_DIGITS-1 wraps to 0.
REQ-019 Sequential mode: KEY[1] event SHALL blank all digits, clear LOADED, set CURSOR to 0; simultaneous KEY[0] and KEY[1] events: clear wins, no write.
REQ-020 Sequential mode: KEY[2..NUM_DIGITS-1] events SHALL be ignored.
REQ-021 A change of synchronized MODE SHALL set CURSOR to 0 on the next edge; digits and LOADED retained; press events in that same cycle are discarded.
REQ-022 Decode (active-low glyphs, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-023 Digits with LOADED=0 SHALL display blank (all segments off); SEG_ACTIVE_LOW=0 inverts every HEX bit.
REQ-024 HEX SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-025 RESET_N low SHALL immediately force: all digits blank, LOADED = 0, CURSOR = 0, debounced levels = not pressed, debounce counters = 0, synchronizers = inactive (KEY high, MODE 0, SW 0).
REQ-026 Reset asserted mid-debounce or mid-press SHALL discard the pending event; a key held through reset release produces an event only after DEBOUNCE_CYCLES + 3 cycles.

Configuration
REQ-027 With HEX_DISP_BLINK_EN defined: in sequential mode the digit at CURSOR SHALL toggle between its glyph and blank every BLINK_CYCLES cycles, phase restarting (glyph visible) on every CURSOR change and on reset; direct mode never blinks.
REQ-028 Without HEX_DISP_BLINK_EN: no blink counter exists; cursor digit displays steadily.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, NUM_DIGITS=4)
REQ-029 Reset, no keys -> HEX = all 1s (28'hFFFFFFF), LOADED=0000, CURSOR=0.
REQ-030 Direct mode, SW=4'hA, KEY[2] low held -> exactly 7 cycles later HEX[20:14]=0001000, LOADED=0100; other digits unchanged.
REQ-031 KEY[0] bouncing (low 2, high 1, low held), SW=3 -> single load, digit0=0110000, counted from last low edge.
REQ-032 Sequential mode, four KEY[0] presses with SW=1,2,3,4 then fifth with SW=F -> digits 3..0 = 4,3,2,F; CURSOR=1.
REQ-033 Sequential mode, KEY[0] and KEY[1] pressed same cycle -> all blank, LOADED=0000, CURSOR=0.
REQ-034 RESET_N pulsed low during a held debounce at count 3 -> no load; outputs at reset values asynchronously.
